// File: rtl/if_id_queue_pkg.sv
// Shared types and sizing for the fetch-to-decode instruction queue.
// Defaults: 4 entries, 32-bit pc and instruction words.
package if_id_queue_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int IFQ_DEPTH   = 4;
  localparam int IFQ_AW      = 2;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_mem.sv
// Entry storage for the instruction queue: one write port, async read.
// All entries clear on reset.
module ifq_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ifq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ifq_entry_t    rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  // Write the addressed entry; reset wipes every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO with first-word-fall-through read and flush.
// Optional same-cycle empty bypass: define IFQ_BYPASS_EN.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [INST_ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0]      in_inst,
  output logic                   in_ready,
  output logic                   stall_req,
  input  logic                   flush,
  output logic                   id_valid,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  input  logic                   id_ready
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic        full, empty;
  logic        byp, push, pop;
  ifq_entry_t  wdata, rdata;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                 (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);

  assign in_ready  = ~full;
  assign stall_req = full;

`ifdef IFQ_BYPASS_EN
  assign byp = empty & in_valid & id_ready & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign push = in_valid & in_ready & ~flush & ~byp;
  assign pop  = ~empty & id_ready & ~flush;

  assign wdata.pc   = in_pc;
  assign wdata.inst = in_inst;

  ifq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // Pointer next-state: flush clears, otherwise advance on push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Head presentation: queue head, bypassed input, or a zero NOP.
  always_comb begin
    id_valid = 1'b0;
    id_pc    = ZERO_WORD;
    id_inst  = ZERO_WORD;
    if (!flush && !empty) begin
      id_valid = 1'b1;
      id_pc    = rdata.pc;
      id_inst  = rdata.inst;
    end else if (byp) begin
      id_valid = 1'b1;
      id_pc    = in_pc;
      id_inst  = in_inst;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue model.
// Honors IFQ_BYPASS_EN the same way the design does.
module tb_if_id_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, stall_req, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_inst;
  logic        id_ready;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  bit do_push, do_pop, cur_fl;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .stall_req (stall_req),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_ready  (id_ready)
  );

  function void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, then compare outputs with the model.
  task automatic drive(input bit v, input logic [31:0] pc,
                       input logic [31:0] inst, input bit rdy,
                       input bit fl);
    int sz;
    bit bp;
    logic [31:0] ep, ei;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_inst = inst;
    id_ready = rdy; flush = fl;
    #1;
    sz = q.size();
    bp = BYP && sz == 0 && v && rdy && !fl;
    chk("id_valid", id_valid, (!fl && (sz > 0 || bp)) ? 1 : 0);
    chk("in_ready", in_ready, (sz < DEPTH) ? 1 : 0);
    chk("stall_req", stall_req, (sz == DEPTH) ? 1 : 0);
    if (!fl) begin
      if (bp) begin
        ep = pc; ei = inst;
      end else if (sz > 0) begin
        ep = q[0][63:32]; ei = q[0][31:0];
      end else begin
        ep = 0; ei = 0;
      end
      chk("id_pc", id_pc, ep);
      chk("id_inst", id_inst, ei);
    end
    do_push = v && sz < DEPTH && !fl && !bp;
    do_pop  = sz > 0 && rdy && !fl;
    cur_fl  = fl;
  endtask

  task automatic step();
    @(posedge clk);
    if (cur_fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({in_pc, in_inst});
    end
  endtask

  task automatic idle(input bit rdy);
    drive(0, 32'hdead_beef, 32'h1234_5678, rdy, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_pc = 0; in_inst = 0;
    flush = 0; id_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_valid", id_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst stall", stall_req, 0);
    chk("rst id_pc", id_pc, 0);
    chk("rst id_inst", id_inst, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then a dropped fifth push.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
      step();
    end
    drive(1, 32'h10, 32'h1010, 0, 0);
    chk("full in_ready", in_ready, 0);
    chk("full stall", stall_req, 1);
    step();

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("drain pc", id_pc, 32'(i * 4));
      step();
    end
    idle(1);
    chk("drained valid", id_valid, 0);
    step();

    // Steady push/pop at two entries, wrapping the pointers.
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'h2000 + 32'(i), 0, 0);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h108 + 32'(k * 4), 32'h2002 + 32'(k), 1, 0);
      chk("pp pc", id_pc, 32'h100 + 32'(k * 4));
      chk("pp in_ready", in_ready, 1);
      step();
    end
    idle(0);
    chk("pp valid", id_valid, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      idle(1);
      step();
    end

    // Flush with three queued and a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(i * 4), 32'h3000 + 32'(i), 0, 0);
      step();
    end
    drive(1, 32'h20, 32'h3020, 0, 1);
    chk("flush valid", id_valid, 0);
    step();
    idle(1);
    chk("post flush valid", id_valid, 0);
    chk("post flush inst", id_inst, 0);
    step();
    idle(1);
    chk("no 0x20 valid", id_valid, 0);
    step();

    // Async reset mid-stream with three queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 32'h4000 + 32'(i), 0, 0);
      step();
    end
    idle(0);
    #2 rst = 1'b1;
    #1;
    chk("mid rst valid", id_valid, 0);
    chk("mid rst ready", in_ready, 1);
    chk("mid rst pc", id_pc, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Empty-queue latency / bypass.
    drive(1, 32'h40, 32'h5040, 1, 0);
    chk("byp same valid", id_valid, BYP ? 1 : 0);
    chk("byp same pc", id_pc, BYP ? 32'h40 : 32'h0);
    step();
    idle(1);
    chk("byp next valid", id_valid, BYP ? 0 : 1);
    chk("byp next pc", id_pc, BYP ? 32'h0 : 32'h40);
    step();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, $urandom, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
